// File: rtl/debounce_edge_detect_pkg.sv
// Shared definitions for the debounce / edge-detect block:
// FSM state encoding and the default parameter values.
package debounce_edge_detect_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DB_CYCLES   = 4;
  localparam int DEF_EVT_W       = 8;

endpackage

// File: rtl/debounce_edge_detect_if.sv
// Signal bundle for the debounce block. The master side drives the raw
// input and the counter clear. The slave side (the block) returns the
// clean level, the edge pulses and the event counter.
interface debounce_edge_detect_if #(
  parameter int EVT_W = 8
);
  logic             D_IN;
  logic             CLR_CNT;
  logic             LEVEL;
  logic             RISE;
  logic             FALL;
  logic [EVT_W-1:0] EVT_CNT;
  logic             OVF;

  modport master (
    output D_IN, CLR_CNT,
    input  LEVEL, RISE, FALL, EVT_CNT, OVF
  );

  modport slave (
    input  D_IN, CLR_CNT,
    output LEVEL, RISE, FALL, EVT_CNT, OVF
  );
endinterface

// File: rtl/debounce_edge_detect_sync_dff_chain.sv
// SYNC_STAGES-deep D-FF chain that brings an asynchronous input into the
// CLK domain. The chain has an async active-low reset, so every stage
// clears to 0 at once.
module sync_dff_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the raw input through the chain; stage 0 is the only D_IN sampler
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_edge_detect.sv
// Input conditioner. It synchronises a raw bouncing input, then debounces
// it with a four-state FSM. Outputs are a registered clean level,
// one-cycle rise/fall pulses and a saturating rise counter with a
// sticky overflow flag.
module debounce_edge_detect
  import debounce_edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int EVT_W       = DEF_EVT_W
) (
  input  logic CLK,
  input  logic RESET,
  debounce_edge_detect_if.slave bus
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic             w_s;
  logic             w_rise_evt;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic [EVT_W-1:0] r_evt_cnt;
  logic             r_ovf;

  sync_dff_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .i_d   (bus.D_IN),
    .o_q   (w_s)
  );

  // The counter sees the same edge that sets RISE, so both update together.
  assign w_rise_evt = (r_state == CHK_HI) && w_s && (r_cnt == CNT_LAST);

  // Debounce FSM: a new level needs DB_CYCLES consecutive equal samples.
  // The first of those samples is counted on entry to the CHK state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        IDLE_LO: if (w_s) begin
          r_state <= CHK_HI;
          r_cnt   <= CW'(1);
        end
        CHK_HI: begin
          if (!w_s) begin
            r_state <= IDLE_LO;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= IDLE_HI;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_rise  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        IDLE_HI: if (!w_s) begin
          r_state <= CHK_LO;
          r_cnt   <= CW'(1);
        end
        CHK_LO: begin
          if (w_s) begin
            r_state <= IDLE_HI;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= IDLE_LO;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_fall  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE_LO;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Rise counter: it saturates at all-ones and sets a sticky OVF.
  // A clear on the same edge as a rise keeps that rise, so the count becomes 1.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_evt_cnt <= '0;
      r_ovf     <= 1'b0;
    end else if (bus.CLR_CNT) begin
      r_evt_cnt <= w_rise_evt ? EVT_W'(1) : '0;
      r_ovf     <= 1'b0;
    end else if (w_rise_evt) begin
      if (&r_evt_cnt) r_ovf     <= 1'b1;
      else            r_evt_cnt <= r_evt_cnt + EVT_W'(1);
    end
  end

  assign bus.LEVEL   = r_level;
  assign bus.RISE    = r_rise;
  assign bus.FALL    = r_fall;
  assign bus.EVT_CNT = r_evt_cnt;
  assign bus.OVF     = r_ovf;

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Scoreboard bench for debounce_edge_detect (SYNC=2, DB=4, EVT_W=2).
// Stimulus pushes each expected pulse (its kind, edge number, counter and
// ovf) into a queue. A negedge monitor pops and compares that entry
// whenever RISE or FALL is seen.
module tb_debounce_edge_detect;
  import debounce_edge_detect_pkg::*;

  typedef struct {
    bit rise;
    int cyc;
    int cnt;
    bit ovf;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q[$];

  debounce_edge_detect_if #(.EVT_W(2)) bif ();

  debounce_edge_detect #(.SYNC_STAGES(2), .DB_CYCLES(4), .EVT_W(2)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bif)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input bit rise, input int c, input int cnt, input bit ovf);
    exp_t e;
    e.rise = rise; e.cyc = c; e.cnt = cnt; e.ovf = ovf;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Clean press: rise 6 edges after going high, fall 6 edges after going low
  task automatic press(input int cnt, input bit ovf);
    bif.D_IN = 1'b1;
    expect_pulse(1'b1, cyc + 6, cnt, ovf);
    step(8);
    bif.D_IN = 1'b0;
    expect_pulse(1'b0, cyc + 6, cnt, ovf);
    step(8);
  endtask

  task automatic pulse_clr();
    bif.CLR_CNT = 1'b1;
    step(1);
    bif.CLR_CNT = 1'b0;
  endtask

  // Monitor: each edge pulse must match the head of the expected queue
  always @(negedge CLK) begin
    exp_t e;
    if (bif.RISE && bif.FALL) chk("rise_fall_both", 1, 0);
    if (bif.RISE || bif.FALL) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: rise=%0d fall=%0d cyc %0d", bif.RISE, bif.FALL, cyc);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", int'(bif.RISE), int'(e.rise));
        chk("pulse_cyc", cyc, e.cyc);
        chk("pulse_evt_cnt", int'(bif.EVT_CNT), e.cnt);
        chk("pulse_ovf", int'(bif.OVF), int'(e.ovf));
        chk("pulse_level", int'(bif.LEVEL), int'(e.rise));
      end
    end
  end

  initial begin
    int t;
    bif.D_IN = 1'b1;
    bif.CLR_CNT = 1'b0;

    // 1: reset held with D_IN high -> outputs 0; after release a full debounce runs
    step(3);
    chk("rst_level", int'(bif.LEVEL), 0);
    chk("rst_rise", int'(bif.RISE), 0);
    chk("rst_fall", int'(bif.FALL), 0);
    chk("rst_evt_cnt", int'(bif.EVT_CNT), 0);
    chk("rst_ovf", int'(bif.OVF), 0);
    RESET = 1'b1;
    expect_pulse(1'b1, cyc + 6, 1, 1'b0);
    step(10);
    chk("t1_level_hi", int'(bif.LEVEL), 1);
    bif.D_IN = 1'b0;
    expect_pulse(1'b0, cyc + 6, 1, 1'b0);
    step(10);

    // 2: 3-sample glitch is rejected
    bif.D_IN = 1'b1;
    step(3);
    bif.D_IN = 1'b0;
    step(10);
    chk("t2_level_lo", int'(bif.LEVEL), 0);
    chk("t2_evt_cnt", int'(bif.EVT_CNT), 1);

    // 3: 12-edge press, one rise and one fall
    bif.D_IN = 1'b1;
    expect_pulse(1'b1, cyc + 6, 2, 1'b0);
    step(12);
    chk("t3_level_hi", int'(bif.LEVEL), 1);
    bif.D_IN = 1'b0;
    expect_pulse(1'b0, cyc + 6, 2, 1'b0);
    step(10);
    chk("t3_level_lo", int'(bif.LEVEL), 0);

    // 4: bounce 1,0,1,1,0,1 then steady 1; rise 6 edges after the last 0->1
    bif.D_IN = 1'b1; step(1);
    bif.D_IN = 1'b0; step(1);
    bif.D_IN = 1'b1; step(2);
    bif.D_IN = 1'b0; step(1);
    bif.D_IN = 1'b1;
    expect_pulse(1'b1, cyc + 6, 3, 1'b0);
    step(10);
    bif.D_IN = 1'b0;
    expect_pulse(1'b0, cyc + 6, 3, 1'b0);
    step(10);

    // 5: saturation with EVT_W=2, then the clear cases
    pulse_clr();
    chk("t5_clr_cnt", int'(bif.EVT_CNT), 0);
    chk("t5_clr_ovf", int'(bif.OVF), 0);
    press(1, 1'b0);
    press(2, 1'b0);
    press(3, 1'b0);
    press(3, 1'b1);
    chk("t5_sat_ovf", int'(bif.OVF), 1);
    pulse_clr();
    chk("t5_clr2_cnt", int'(bif.EVT_CNT), 0);
    chk("t5_clr2_ovf", int'(bif.OVF), 0);
    press(1, 1'b0);
    // Clear lands on the same edge as the rise: the count becomes 1, not 2
    bif.D_IN = 1'b1;
    t = cyc;
    expect_pulse(1'b1, t + 6, 1, 1'b0);
    step(5);
    bif.CLR_CNT = 1'b1;
    step(1);
    bif.CLR_CNT = 1'b0;
    step(4);
    bif.D_IN = 1'b0;
    expect_pulse(1'b0, cyc + 6, 1, 1'b0);
    step(10);

    // 6: async reset while in CHK_HI with cnt=2
    bif.D_IN = 1'b1;
    step(4);
    #2;
    chk("t6_pre_state", int'(dut.r_state), int'(CHK_HI));
    chk("t6_pre_cnt", int'(dut.r_cnt), 2);
    RESET = 1'b0;
    #1;
    chk("t6_rst_sync", int'(dut.u_sync.r_sync), 0);
    chk("t6_rst_cnt", int'(dut.r_cnt), 0);
    chk("t6_rst_state", int'(dut.r_state), int'(IDLE_LO));
    chk("t6_rst_evt_cnt", int'(bif.EVT_CNT), 0);
    chk("t6_rst_level", int'(bif.LEVEL), 0);
    step(2);
    RESET = 1'b1;
    expect_pulse(1'b1, cyc + 6, 1, 1'b0);
    step(10);
    bif.D_IN = 1'b0;
    expect_pulse(1'b0, cyc + 6, 1, 1'b0);
    step(10);

    chk("pending_expected", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
